// File: rtl/fetch_inst_queue_pkg.sv
// Types and default geometry for the fetch-to-decode instruction queue.
// Holds no logic and adds no latency.
package fetch_inst_queue_pkg;

  localparam int DECODER_WIDTH   = 2;
  localparam int FQ_FETCH_WIDTH  = 2;
  localparam int FQ_DECODE_WIDTH = DECODER_WIDTH;
  localparam int FQ_DEPTH        = 16;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [5:0]       is_exception;
    logic [5:0][6:0]  exception_cause;
    logic             pre_is_branch;
    logic             pre_is_branch_taken;
    logic [31:0]      pre_branch_addr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// Adds no latency; in_ready/out_ready carry the backpressure in each direction.
interface fetch_inst_queue_if #(
  parameter int FETCH_WIDTH  = fetch_inst_queue_pkg::FQ_FETCH_WIDTH,
  parameter int DECODE_WIDTH = fetch_inst_queue_pkg::FQ_DECODE_WIDTH,
  parameter int CNT_W        = $clog2(fetch_inst_queue_pkg::FQ_DEPTH + 1)
);

  logic                                                flush;
  logic [FETCH_WIDTH-1:0]                              in_valid;
  fetch_inst_queue_pkg::fq_entry_t [FETCH_WIDTH-1:0]   in_entry;
  logic                                                in_ready;
  logic [DECODE_WIDTH-1:0]                             out_valid;
  fetch_inst_queue_pkg::fq_entry_t [DECODE_WIDTH-1:0]  out_entry;
  logic                                                out_ready;
  logic [CNT_W-1:0]                                    count;

  modport master (
    output flush, in_valid, in_entry, out_ready,
    input  in_ready, out_valid, out_entry, count
  );

  modport slave (
    input  flush, in_valid, in_entry, out_ready,
    output in_ready, out_valid, out_entry, count
  );

endinterface

// File: rtl/fetch_inst_queue_lane_compact.sv
// Prefix popcount of a lane mask: per-lane compacted offset plus total set lanes.
// Purely combinational; no latency, no backpressure.
module fq_lane_compact #(
  parameter int W  = 2,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         lane_valid,
  output logic [W-1:0][CW-1:0] offset,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < W; i++) begin
      offset[i] = acc;
      acc       = acc + CW'(lane_valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/fetch_inst_queue.sv
// Circular instruction queue: compacts up to FETCH_WIDTH valid lanes in, presents DECODE_WIDTH oldest out.
// Push visible next cycle; all-or-nothing accept while room for a full group; flush empties on next edge.
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int FETCH_WIDTH  = FQ_FETCH_WIDTH,
  parameter int DECODE_WIDTH = FQ_DECODE_WIDTH,
  parameter int DEPTH        = FQ_DEPTH,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_inst_queue_if.slave      fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FW_CW = $clog2(FETCH_WIDTH + 1);
  localparam int DW_CW = $clog2(DECODE_WIDTH + 1);
  localparam logic [CNT_W-1:0] PUSH_LIMIT = CNT_W'(DEPTH - FETCH_WIDTH);

  fq_entry_t mem [DEPTH];

  logic [PTR_W-1:0]                     head;
  logic [PTR_W-1:0]                     tail;
  logic [CNT_W-1:0]                     count;
  logic [FETCH_WIDTH-1:0][FW_CW-1:0]    push_offset;
  logic [FW_CW-1:0]                     push_total;
  logic [DECODE_WIDTH-1:0][DW_CW-1:0]   pop_offset_unused;
  logic [DW_CW-1:0]                     pop_total;
  logic [DECODE_WIDTH-1:0]              out_valid;
  logic                                 in_ready;
  logic                                 push_fire;
  logic                                 pop_fire;
  logic [CNT_W-1:0]                     push_n;
  logic [CNT_W-1:0]                     pop_n;

  fq_lane_compact #(.W(FETCH_WIDTH), .CW(FW_CW)) u_push_compact (
    .lane_valid (fq.in_valid),
    .offset     (push_offset),
    .total      (push_total)
  );

  // out_valid is contiguous, so its popcount is the number of entries decode takes
  fq_lane_compact #(.W(DECODE_WIDTH), .CW(DW_CW)) u_pop_compact (
    .lane_valid (out_valid),
    .offset     (pop_offset_unused),
    .total      (pop_total)
  );

  always_comb begin
    in_ready      = (count <= PUSH_LIMIT);
    out_valid     = '0;
    fq.out_entry  = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      out_valid[k]    = (count > CNT_W'(k));
      fq.out_entry[k] = mem[head + PTR_W'(k)];
    end
  end

  assign fq.in_ready  = in_ready;
  assign fq.out_valid = out_valid;
  assign fq.count     = count;

  assign push_fire = (|fq.in_valid) & in_ready & ~fq.flush;
  assign pop_fire  = fq.out_ready & out_valid[0] & ~fq.flush;
  assign push_n    = push_fire ? CNT_W'(push_total) : '0;
  assign pop_n     = pop_fire  ? CNT_W'(pop_total)  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_fire) tail <= tail + PTR_W'(push_total);
      if (pop_fire)  head <= head + PTR_W'(pop_total);
      count <= count + push_n - pop_n;
    end
  end

  // Storage is deliberately unreset; pointers and count define what is live
  always_ff @(posedge clk) begin
    if (push_fire) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (fq.in_valid[i]) mem[tail + PTR_W'(push_offset[i])] <= fq.in_entry[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed and randomized-stream checks of fetch_inst_queue with FETCH_WIDTH=DECODE_WIDTH=2, DEPTH=16.
module tb_fetch_inst_queue;
  import fetch_inst_queue_pkg::*;

  localparam int FW = 2;
  localparam int DW = 2;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  int          exp_count;
  logic [31:0] next_exp_pc;
  logic [31:0] next_push_pc;

  fetch_inst_queue_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .CNT_W(CW)) fq ();

  fetch_inst_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  function automatic fq_entry_t mk_entry(input logic [31:0] pc);
    fq_entry_t e;
    e.pc           = pc;
    e.inst         = {pc[15:0], ~pc[31:16]};
    e.is_exception = pc[7:2];
    for (int i = 0; i < 6; i++) e.exception_cause[i] = pc[6:0] + 7'(i);
    e.pre_is_branch       = pc[2];
    e.pre_is_branch_taken = pc[3];
    e.pre_branch_addr     = pc + 32'h40;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic ordy, input logic fl);
    fq.in_valid    = mask;
    fq.in_entry[0] = mk_entry(pc0);
    fq.in_entry[1] = mk_entry(pc1);
    fq.out_ready   = ordy;
    fq.flush       = fl;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // One cycle against the sequential-pc stream: check state, drive, advance expectations
  task automatic stream_step(input logic forced, input logic [1:0] fmask, input logic fordy);
    logic [1:0]  mask;
    logic        ordy;
    logic [31:0] lane_pc [FW];
    int          nv;
    int          popn;
    logic        accept;
    chk("stream_count", fq.count, exp_count);
    chk("stream_count_bound", (fq.count <= DEPTH), 1'b1);
    chk("stream_in_ready", fq.in_ready, (exp_count <= DEPTH - FW));
    for (int k = 0; k < DW; k++) begin
      chk("stream_out_valid", fq.out_valid[k], (exp_count > k));
      if (exp_count > k) chk("stream_pc", fq.out_entry[k], mk_entry(next_exp_pc + 32'(4 * k)));
    end
    mask = forced ? fmask : 2'($urandom_range(0, 3));
    ordy = forced ? fordy : 1'($urandom_range(0, 1));
    nv = 0;
    for (int i = 0; i < FW; i++) begin
      if (mask[i]) begin
        lane_pc[i] = next_push_pc + 32'(4 * nv);
        nv++;
      end else begin
        lane_pc[i] = 32'hBAD0_0000 + 32'(4 * i);
      end
    end
    accept = (mask != 2'b00) && (exp_count <= DEPTH - FW);
    popn   = ordy ? ((exp_count < DW) ? exp_count : DW) : 0;
    drive(mask, lane_pc[0], lane_pc[1], ordy, 1'b0);
    tick();
    if (accept) begin
      next_push_pc = next_push_pc + 32'(4 * nv);
      exp_count    = exp_count + nv;
    end
    next_exp_pc = next_exp_pc + 32'(4 * popn);
    exp_count   = exp_count - popn;
  endtask

  localparam logic [31:0] FILL = 32'h1c00_1000;

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk("reset_in_ready", fq.in_ready, 1'b1);
    chk("reset_out_valid", fq.out_valid, 2'b00);
    chk("reset_count", fq.count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Two valid lanes, decode paused
    drive(2'b11, 32'h1c00_0000, 32'h1c00_0004, 1'b0, 1'b0);
    chk("no_bypass", fq.out_valid, 2'b00);
    tick();
    idle();
    chk("push2_out_valid", fq.out_valid, 2'b11);
    chk("push2_count", fq.count, 2);
    chk("push2_entry0", fq.out_entry[0], mk_entry(32'h1c00_0000));
    chk("push2_entry1", fq.out_entry[1], mk_entry(32'h1c00_0004));

    // Only lane 1 valid: compacted into the tail slot
    drive(2'b10, 32'h0BAD_BEEC, 32'h1c00_0008, 1'b0, 1'b0);
    tick();
    idle();
    chk("lane1_count", fq.count, 3);
    chk("lane1_out_valid_paused", fq.out_valid, 2'b11);
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    idle();
    chk("lane1_count_after_pop", fq.count, 1);
    chk("lane1_out_valid", fq.out_valid, 2'b01);
    chk("lane1_entry0", fq.out_entry[0], mk_entry(32'h1c00_0008));
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    idle();
    chk("drain_count", fq.count, 0);
    chk("drain_out_valid", fq.out_valid, 2'b00);

    // Fill to 15 starting at head=3 so storage wraps
    for (int c = 0; c < 7; c++) begin
      chk("fill_in_ready", fq.in_ready, 1'b1);
      drive(2'b11, FILL + 32'(8 * c), FILL + 32'(8 * c + 4), 1'b0, 1'b0);
      tick();
      idle();
      chk("fill_count", fq.count, 2 * (c + 1));
    end
    chk("fill14_in_ready", fq.in_ready, 1'b1);
    drive(2'b01, FILL + 32'd56, 32'h0BAD_0000, 1'b0, 1'b0);
    tick();
    idle();
    chk("full_count", fq.count, 15);
    chk("full_in_ready", fq.in_ready, 1'b0);
    for (int c = 0; c < 2; c++) begin
      drive(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 1'b0, 1'b0);
      tick();
      idle();
      chk("full_hold_count", fq.count, 15);
      chk("full_hold_in_ready", fq.in_ready, 1'b0);
    end
    chk("full_entry0", fq.out_entry[0], mk_entry(FILL));
    chk("full_entry1", fq.out_entry[1], mk_entry(FILL + 32'd4));
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    idle();
    chk("unfull_count", fq.count, 13);
    chk("unfull_in_ready", fq.in_ready, 1'b1);
    chk("unfull_entry0", fq.out_entry[0], mk_entry(FILL + 32'd8));

    // Random push/pop on a sequential pc stream, then drain
    exp_count    = 13;
    next_exp_pc  = FILL + 32'd8;
    next_push_pc = FILL + 32'd60;
    for (int c = 0; c < 40; c++) stream_step(1'b0, 2'b00, 1'b0);
    for (int g = 0; g < 20 && exp_count != 0; g++) stream_step(1'b1, 2'b00, 1'b1);
    chk("stream_drained", fq.count, 0);
    chk("stream_exp_drained", exp_count, 0);
    idle();

    // Flush with simultaneous push and pop at count=6
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 32'h1c00_2000 + 32'(8 * c), 32'h1c00_2004 + 32'(8 * c), 1'b0, 1'b0);
      tick();
    end
    idle();
    chk("preflush_count", fq.count, 6);
    drive(2'b11, 32'h1c00_2F00, 32'h1c00_2F04, 1'b1, 1'b1);
    tick();
    idle();
    chk("flush_count", fq.count, 0);
    chk("flush_out_valid", fq.out_valid, 2'b00);
    chk("flush_in_ready", fq.in_ready, 1'b1);
    drive(2'b01, 32'h1c00_3000, 32'h0BAD_0004, 1'b0, 1'b0);
    tick();
    idle();
    chk("postflush_out_valid", fq.out_valid, 2'b01);
    chk("postflush_entry0", fq.out_entry[0], mk_entry(32'h1c00_3000));

    // Held flush: nothing is accepted
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 32'h1c00_4000, 32'h1c00_4004, 1'b0, 1'b1);
      tick();
      chk("hold_flush_count", fq.count, 0);
      chk("hold_flush_in_ready", fq.in_ready, 1'b1);
      chk("hold_flush_out_valid", fq.out_valid, 2'b00);
    end
    idle();

    // Asynchronous reset mid-stream at count=9
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 32'h1c00_5000 + 32'(8 * c), 32'h1c00_5004 + 32'(8 * c), 1'b0, 1'b0);
      tick();
    end
    drive(2'b01, 32'h1c00_5020, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    chk("prereset_count", fq.count, 9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", fq.count, 0);
    chk("async_reset_out_valid", fq.out_valid, 2'b00);
    chk("async_reset_in_ready", fq.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(2'b01, 32'h1c00_6000, 32'h0, 1'b0, 1'b0);
    chk("postreset_no_bypass", fq.out_valid, 2'b00);
    tick();
    idle();
    chk("postreset_out_valid", fq.out_valid, 2'b01);
    chk("postreset_count", fq.count, 1);
    chk("postreset_entry0", fq.out_entry[0], mk_entry(32'h1c00_6000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Parametrised instruction queue between the fetch stage and the decoders. Accepts up to FETCH_WIDTH instructions per cycle, with a per-lane valid mask and in-order compaction of valid lanes. Presents up to DECODE_WIDTH oldest entries per cycle, always packed from lane 0. Supports full flush (exception or branch redirect) and decode-side pause. It generalises the fixed two-lane fetch-to-decode bundle to arbitrary fetch/decode widths and queue depth.

## Interface
- FETCH_WIDTH, 2, instructions offered per cycle by fetch
- DECODE_WIDTH, 2, instructions presented per cycle to decode
- DEPTH, 16, entry count; power of two, ≥ 2*max(FETCH_WIDTH, DECODE_WIDTH)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all entries (exception_flush or branch redirect)
- in_valid  in  FETCH_WIDTH  per-lane valid; lane 0 is oldest
- in_entry  in  FETCH_WIDTH × fq_entry_t  pc, inst, is_exception[5:0], exception_cause[5:0][6:0], pre_is_branch, pre_is_branch_taken, pre_branch_addr
- in_ready  out  1  queue can take a full FETCH_WIDTH group this cycle
- out_valid  out  DECODE_WIDTH  contiguous mask; lane k valid implies lanes 0..k-1 valid
- out_entry  out  DECODE_WIDTH × fq_entry_t  oldest entries, lane 0 oldest
- out_ready  in  1  decode consumes every valid out lane this cycle (low = pause_id)
- count  out  CNT_W  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in count.
- push_fire = |in_valid & in_ready & !flush. Valid lanes are written in lane order to tail, tail+1, …, skipping invalid lanes (compaction). tail advances by popcount(in_valid).
- in_ready = (DEPTH − count) ≥ FETCH_WIDTH. Acceptance is all-or-nothing. in_ready is computed from the pre-pop count, so it is conservative and has no combinational path from out_ready.
- out_valid[k] = (count > k). out_entry[k] = mem[head+k mod DEPTH]. Lanes with out_valid low carry don't-care data; the bench must not check them.
- pop_fire = out_ready & out_valid[0] & !flush. head advances by popcount(out_valid).
- count_next = count + pushed − popped. The arithmetic must never underflow or overflow. The bench asserts count ≤ DEPTH.
- flush: head, tail and count return to 0 on the next edge. Same-cycle push and pop are both discarded, so flush has priority over both.
- Entry contents pass through bit-exact. The queue never inspects or modifies exception or prediction fields.
- Reset (async, mid-operation allowed): head = tail = count = 0. Storage is not reset.
- Reset values: in_ready = 1, out_valid = 0, count = 0. out_entry is don't-care.

## Timing
- Push-to-visible latency is 1 cycle. An entry written at edge N appears on out_entry from cycle N+1. There is no bypass path from in_entry to out_entry.
- Simultaneous push and pop: both take effect at the same edge. Pop drains pre-existing entries only.
- Empty with push: out_valid rises next cycle.
- Full (count > DEPTH − FETCH_WIDTH): in_ready low. It recovers the cycle after a pop makes space.
- Wrap-around: writes and reads spanning index DEPTH−1 to 0 within one group must be seamless.
- flush asserted for several cycles: the queue stays empty, in_ready stays high, and nothing is accepted.
- in_ready depends only on registered state. out_valid and out_entry depend only on registered state.

## Structure
- fq_entry_t goes in pipeline_types as a packed struct. The FETCH_WIDTH / DECODE_WIDTH / FQ_DEPTH constants also go there. DECODE_WIDTH defaults to the existing DECODER_WIDTH.
- One sub-module, fq_lane_compact, is purely combinational. From in_valid it produces per-lane write offsets (prefix popcount) and the total push count, and it is reused for pop-count logic.
- The top level holds the storage array, pointers, count, and the flush/reset logic.

## Test plan
- Reset, then push 2 valid lanes {pc 0x1c000000, 0x1c000004} with out_ready=0 → next cycle out_valid=2'b11, count=2, entries bit-exact.
- in_valid=2'b10 with pc 0x1c000008 in lane 1 → stored at tail; next cycle appears as sole out lane 0, out_valid=2'b01.
- Fill with out_ready=0 until count=15 (DEPTH=16) → in_ready=0. Further pushes are ignored and count holds at 15. One pop of 2 → in_ready=1 the next cycle.
- Run 40 cycles of random push and pop with a sequential pc stream across pointer wrap → decode sees strictly increasing pc with no gaps or duplicates.
- flush in the same cycle as push 2 and pop 2, with count=6 → next cycle count=0, out_valid=0, pushed entries absent.
- Deassert rst_n mid-stream with count=9 → immediately (asynchronously) count=0, out_valid=0, in_ready=1. After release, the next push is seen after 1 cycle.
